// File: rtl/router_pkg.sv
// Shared constants for the router output-port read engine:
// header field positions, default stall timeout, FSM state encoding.
package router_pkg;

  localparam int LEN_MSB  = 7;
  localparam int LEN_LSB  = 2;
  localparam int ADDR_MSB = 1;
  localparam int ADDR_LSB = 0;
  localparam int LEN_W    = LEN_MSB - LEN_LSB + 1;

  localparam int TIMEOUT_DEF = 30;

  localparam logic [1:0] ST_HDR = 2'd0;
  localparam logic [1:0] ST_PAY = 2'd1;
  localparam logic [1:0] ST_PAR = 2'd2;

endpackage

// File: rtl/router_skid_buf.sv
// Two-entry in-order byte buffer feeding the destination port.
// Ports: clk_i/rst_i, clear_i (sync flush), push_i/din_i, pop_i, occ_o, head_o.
module router_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [1:0]       occ_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       occ_q, occ_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (clear_i) begin
      occ_d = 2'd0;
    end else begin
      unique case (1'b1)
        push_i && !pop_i: begin
          if (occ_q == 2'd0) begin
            head_d = din_i;
            occ_d  = 2'd1;
          end else if (occ_q == 2'd1) begin
            tail_d = din_i;
            occ_d  = 2'd2;
          end
        end
        !push_i && pop_i: begin
          if (occ_q != 2'd0) begin
            head_d = tail_q;
            occ_d  = occ_q - 2'd1;
          end
        end
        push_i && pop_i: begin
          // Head leaves while the new byte arrives: it becomes
          // the head if it was alone, otherwise queues behind tail.
          if (occ_q == 2'd1) begin
            head_d = din_i;
          end else if (occ_q == 2'd2) begin
            head_d = tail_q;
            tail_d = din_i;
          end else begin
            head_d = din_i;
            occ_d  = 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign occ_o  = occ_q;
  assign head_o = head_q;

endmodule

// File: rtl/router_out_port.sv
// Router output channel read engine: FIFO read issue, framing FSM,
// parity check, stall timeout with soft_reset.
// Ports: clock/reset, fifo_empty/fifo_data/fifo_read_enb,
// soft_reset, dest_ready/vld_out/data_out, busy, pkt_done, parity_err.
module router_out_port
  import router_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_read_enb,
  output logic             soft_reset,
  input  logic             dest_ready,
  output logic             vld_out,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             pkt_done,
  output logic             parity_err
);

  localparam int SW = $clog2(TIMEOUT + 1);

  logic [1:0]       occ;
  logic [WIDTH-1:0] head;
  logic             pop, push, stalled;
  logic [2:0]       level;

  logic             infl_q;
  logic             soft_q, soft_d;
  logic [SW-1:0]    stall_q, stall_d;
  logic [1:0]       st_q, st_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             done_q, done_d;
  logic             perr_q, perr_d;
  logic [LEN_W-1:0] hdr_len;

  router_skid_buf #(.WIDTH(WIDTH)) u_buf (
    .clk_i   (clock),
    .rst_i   (reset),
    .clear_i (soft_q),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (fifo_data),
    .occ_o   (occ),
    .head_o  (head)
  );

  assign vld_out  = (occ != 2'd0);
  assign data_out = head;
  assign pop      = vld_out & dest_ready;
  assign stalled  = vld_out & ~dest_ready;
  // Data returning during the flush cycle is dropped.
  assign push     = infl_q & ~soft_q;
  assign hdr_len  = head[LEN_MSB:LEN_LSB];

  // Bytes held or on their way after this cycle's pop.
  assign level = {1'b0, occ} + {2'b00, infl_q} - {2'b00, pop};

  assign fifo_read_enb = ~reset & ~fifo_empty & ~soft_q
                       & (level < 3'd2);

  assign soft_reset = soft_q;
  assign busy       = (st_q != ST_HDR);
  assign pkt_done   = done_q;
  assign parity_err = perr_q;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    done_d = 1'b0;
    perr_d = 1'b0;
    if (soft_q) begin
      st_d  = ST_HDR;
      cnt_d = '0;
      acc_d = '0;
    end else if (pop) begin
      unique case (1'b1)
        st_q == ST_HDR: begin
          cnt_d = hdr_len;
          acc_d = head;
          st_d  = (hdr_len == '0) ? ST_PAR : ST_PAY;
        end
        st_q == ST_PAY: begin
          acc_d = acc_q ^ head;
          cnt_d = cnt_q - LEN_W'(1);
          if (cnt_q == LEN_W'(1)) st_d = ST_PAR;
        end
        st_q == ST_PAR: begin
          done_d = 1'b1;
          perr_d = (head != acc_q);
          st_d   = ST_HDR;
        end
        default: st_d = ST_HDR;
      endcase
    end
  end

  always_comb begin
    soft_d  = 1'b0;
    stall_d = '0;
    if (!soft_q && stalled) begin
      stall_d = stall_q + SW'(1);
      soft_d  = (stall_q == SW'(TIMEOUT - 1));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      infl_q  <= 1'b0;
      soft_q  <= 1'b0;
      stall_q <= '0;
      st_q    <= ST_HDR;
      cnt_q   <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      infl_q  <= fifo_read_enb;
      soft_q  <= soft_d;
      stall_q <= stall_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
    end
  end

endmodule
